pll_reset_seq: RTL and testbench

Reset sequencer sitting directly downstream of the 100 MHz rPLL on the Tang Nano 20K board. It consumes the PLL's asynchronous `lock` flag and produces a clean, synchronously-deasserted active-low reset for all logic clocked by the PLL output. Lock is qualified by a stability window before release. Loss of lock re-asserts reset immediately and is counted. A soft-reset request re-runs the hold phase without waiting for re-lock.

---
 rtl/pll_rst_pkg.sv | 24 ++
 rtl/sync_ff.sv | 24 ++
 rtl/pll_reset_seq.sv | 126 ++++++++++++
 tb/tb_pll_reset_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and default parameters for the PLL reset sequencer.
// Latency: n/a (definitions only); backpressure: none.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_LOCK_STABLE_CYC = 1024;
    localparam int DEF_RST_HOLD_CYC    = 16;
    localparam int DEF_LOSS_CNT_W      = 8;

    // Shared counter covers both windows; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer, asynchronously cleared to 0.
// Latency: STAGES clk edges; backpressure: none.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Qualifies PLL lock, then releases a synchronously-deasserted domain reset.
// Latency: SYNC_STAGES+1+LOCK_STABLE_CYC+RST_HOLD_CYC edges to release; backpressure: none.
module pll_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int RST_HOLD_CYC    = DEF_RST_HOLD_CYC,
    parameter int LOSS_CNT_W      = DEF_LOSS_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lock,
    input  logic                  soft_rst,
    output logic                  sys_rst_n,
    output logic                  pll_ok,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYC, RST_HOLD_CYC);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYC - 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("pll_reset_seq: SYNC_STAGES must be >= 2");
    end
    if (LOCK_STABLE_CYC < 1) begin : g_chk_stable
        $error("pll_reset_seq: LOCK_STABLE_CYC must be >= 1");
    end
    if (RST_HOLD_CYC < 1) begin : g_chk_hold
        $error("pll_reset_seq: RST_HOLD_CYC must be >= 1");
    end

    logic                  lock_s;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  loss_d;
    logic                  sys_rst_n_q, pll_ok_q, lock_lost_q;
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (lock),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    loss_d  = 1'b1;
                end else if (soft_rst) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Lock loss outranks a concurrent soft reset request.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    loss_d  = 1'b1;
                end else if (soft_rst) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            pll_ok_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= (state_d == RUN);
            pll_ok_q    <= (state_d == HOLD) || (state_d == RUN);
            lock_lost_q <= loss_d;
            if (loss_d && (loss_cnt_q != '1)) begin
                loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
            end
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign pll_ok    = pll_ok_q;
    assign lock_lost = lock_lost_q;
    assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: directed scenarios then random lock/soft traffic.
// Expectations come from a run-length model of the lock qualification rules.
module tb_pll_reset_seq;

    localparam int SS = 2;
    localparam int L  = 8;
    localparam int H  = 4;
    localparam int LW = 2;
    localparam int SAT = (1 << LW) - 1;

    typedef struct {
        logic          sys_rst_n;
        logic          pll_ok;
        logic          lock_lost;
        logic [LW-1:0] loss_cnt;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          lock;
    logic          soft_rst;
    logic          sys_rst_n;
    logic          pll_ok;
    logic          lock_lost;
    logic [LW-1:0] loss_cnt;

    int n_vec = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    // Reference model state: synchronizer image plus run-length bookkeeping.
    bit m_s1, m_s2;
    int m_run;
    bit m_qual;
    int m_free;
    int m_losses;

    pll_reset_seq #(
        .SYNC_STAGES     (SS),
        .LOCK_STABLE_CYC (L),
        .RST_HOLD_CYC    (H),
        .LOSS_CNT_W      (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lock      (lock),
        .soft_rst  (soft_rst),
        .sys_rst_n (sys_rst_n),
        .pll_ok    (pll_ok),
        .lock_lost (lock_lost),
        .loss_cnt  (loss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        exp_t e;
        m_s1 = 0; m_s2 = 0; m_run = 0; m_qual = 0; m_free = 0; m_losses = 0;
        e.sys_rst_n = 1'b0;
        e.pll_ok    = 1'b0;
        e.lock_lost = 1'b0;
        e.loss_cnt  = '0;
        exp_q.push_back(e);
    endtask

    // Lock qualifies after L+1 consecutive synchronized-high samples; release
    // needs H consecutive soft-free locked samples after qualification.
    task automatic model_edge(input bit l, input bit s);
        exp_t e;
        bit ls;
        bit lost;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = l;
        lost = 0;
        if (!m_qual) begin
            m_run = ls ? m_run + 1 : 0;
            if (m_run == L + 1) begin
                m_qual = 1;
                m_free = 0;
            end
        end else if (!ls) begin
            m_qual = 0;
            m_run  = 0;
            lost   = 1;
            if (m_losses < SAT) m_losses++;
        end else if (s) begin
            m_free = 0;
        end else begin
            m_free++;
        end
        e.sys_rst_n = m_qual && (m_free >= H);
        e.pll_ok    = m_qual;
        e.lock_lost = lost;
        e.loss_cnt  = LW'(m_losses);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit l, input bit s);
        @(negedge clk);
        rst_n    = r;
        lock     = l;
        soft_rst = s;
        @(posedge clk);
        model_edge(l, s);
    endtask

    task automatic cycs(input int n, input bit r, input bit l, input bit s);
        for (int i = 0; i < n; i++) cyc(r, l, s);
    endtask

    task automatic async_rst();
        #2;
        rst_n = 1'b0;
        model_reset();
    endtask

    task automatic cmp(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("sys_rst_n", int'(sys_rst_n), int'(e.sys_rst_n));
                cmp("pll_ok",    int'(pll_ok),    int'(e.pll_ok));
                cmp("lock_lost", int'(lock_lost), int'(e.lock_lost));
                cmp("loss_cnt",  int'(loss_cnt),  int'(e.loss_cnt));
            end
        end
    end

    initial begin : stim
        bit s_lvl;
        int hi, lo;
        rst_n    = 1'b0;
        lock     = 1'b0;
        soft_rst = 1'b0;
        model_reset();

        cycs(3, 0, 0, 0);
        // Clean bring-up, then a 6-cycle soft reset in RUN.
        cycs(20, 1, 1, 0);
        cycs(6, 1, 1, 1);
        cycs(8, 1, 1, 0);
        // Loss in RUN and re-lock.
        cycs(5, 1, 0, 0);
        cycs(20, 1, 1, 0);
        // Repeated losses drive the counter into saturation.
        for (int k = 0; k < 5; k++) begin
            cycs(4, 1, 0, 0);
            cycs(20, 1, 1, 0);
        end
        // Soft reset and lock drop together.
        cyc(1, 0, 1);
        cycs(4, 1, 0, 0);
        // Unstable lock never qualifies, then a clean rise.
        cycs(5, 1, 1, 0);
        cycs(3, 1, 0, 0);
        cycs(20, 1, 1, 0);
        // Asynchronous reset in the middle of HOLD.
        cycs(4, 1, 0, 0);
        cycs(12, 1, 1, 0);
        async_rst();
        cycs(2, 0, 1, 0);
        cycs(20, 1, 1, 0);

        // Random lock segments with sporadic soft-reset bursts.
        s_lvl = 0;
        for (int seg = 0; seg < 60; seg++) begin
            hi = $urandom_range(1, 40);
            lo = $urandom_range(1, 6);
            for (int i = 0; i < hi; i++) begin
                if ($urandom_range(0, 9) == 0) s_lvl = ~s_lvl;
                cyc(1, 1, s_lvl);
            end
            for (int i = 0; i < lo; i++) cyc(1, 0, ($urandom_range(0, 3) == 0));
            if (seg == 30) begin
                async_rst();
                cycs($urandom_range(1, 3), 0, $urandom_range(0, 1) == 1, 0);
            end
        end

        @(negedge clk);
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
